grid_vga_display: RTL and testbench
===================================

// Module: grid_vga_display
// PURPOSE
// - Downstream consumer of the 16x16 playfield vector (256-bit grid from grid logic); renders it on 640x480@60Hz VGA.
// - Owns VGA timing (pixel-tick divider, h/v counters, syncs), a tear-free per-frame grid snapshot, and a registered RGB pixel stage.
// - Emits frame_start once per frame so game logic can pace its gravity tick off the display.
// PARAMETERS
// - CLK_DIV   4       system clocks per pixel (100 MHz -> 25 MHz pixel rate)
// - CELL_PX   16      pixel edge of one grid cell (power of two)
// - X0        192     left pixel column of playfield (256 px wide, centred)
// - Y0        112     top pixel row of playfield (256 px tall, centred)
// - FILL_RGB  12'hF80 colour of occupied cell
// - EMPTY_RGB 12'h111 colour of empty cell
// - LINE_RGB  12'h444 colour of 1-px cell outline (pixel offset 0 within cell, x or y)
// PORTS
// - clk          in   1    100 MHz system clock
// - reset        in   1    synchronous, active-low reset
// - grid_in      in   256  playfield; cell (x,y), x=col 0..15, y=row 0..15 (row 0 top) at bit x*16+y
// - vga_r        out  4    red
// - vga_g        out  4    green
// - vga_b        out  4    blue
// - vga_hs       out  1    hsync, active-low
// - vga_vs       out  1    vsync, active-low
// - frame_start  out  1    1-clk pulse when snapshot is taken
// BEHAVIOUR
// - One clock; reset is synchronous and active-low: sampled on rising clk edge when reset==0.
// - Reset values: div=0, h=0, v=0, snapshot=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, frame_start=0. Reset mid-frame restarts at (h,v)=(0,0) on first tick after release.
// - tick asserts one clk in every CLK_DIV, first in the CLK_DIV-th cycle after reset release (div counts 0..CLK_DIV-1, tick when div==CLK_DIV-1).
// - On tick: h increments 0..799, wraps to 0; on h wrap, v increments 0..524, wraps to 0. Counters hold between ticks.
// - Horizontal: visible 0-639, FP 640-655, sync 656-751, BP 752-799. Vertical: visible 0-479, FP 480-489, sync 490-491, BP 492-524.
// - Snapshot: on the tick where (h,v)==(0,480), snapshot<=grid_in and frame_start=1 in the same clk cycle as that tick's output update; 0 otherwise.
//   grid_in changes at any other time never affect the displayed frame.
// - Pixel stage: on each tick, outputs are registered from current (h,v) (counter values before that tick's increment); one-tick latency, syncs and RGB aligned.
//   vga_hs=0 iff 656<=h<=751; vga_vs=0 iff 490<=v<=491.
//   outside visible area: RGB=0. Visible but outside [X0,X0+256)x[Y0,Y0+256): RGB=0.
//   inside: cx=(h-X0)/CELL_PX, cy=(v-Y0)/CELL_PX (shift, no divider); px/py = offset within cell.
//   px==0 or py==0 -> LINE_RGB; else snapshot[cx*16+cy] ? FILL_RGB : EMPTY_RGB.
// - Width rules: h,v 10-bit; subtractions done in 10-bit after range check, so no negative indices reach cell logic.
// - Outputs hold between ticks (vga pins change only on tick cycles).
// STRUCTURE
// - Shared include tetris_defs.vh: H/V visible/FP/sync/BP constants, H_TOTAL=800, V_TOTAL=525, GRID_W=16, GRID_H=16, colour constants.
// - Sub-module vga_timing: divider, h/v counters, tick, hsync/vsync raw, visible flag; parent does snapshot, cell lookup, output registers.
// TESTING
// - Reset held 10 clks then released -> hs=vs=1, RGB=0; first tick after 4 clks; h advances every 4 clks.
// - Run one line -> vga_hs low exactly 96 ticks (384 clks) starting at registered h=656; line period 3200 clks.
// - Run one frame -> vga_vs low 2 lines (6400 clks); frame period 1,680,000 clks; exactly one frame_start per frame at (0,480).
// - grid_in bit 0 set (cell 0,0) -> pixel (193,113) = F80, (192,113) = 444, (209,113) = 111, (191,113) = 000.
// - grid_in bit 255 set (cell 15,15) -> pixel (447,367) = F80; pixel (448,367) = 000.
// - Change grid_in during visible lines (v=200) -> current frame unchanged; new value appears only after next frame_start.
// - Assert reset at h=300,v=200 -> after release, outputs restart from (0,0) timing; frame_start next seen 480 lines later.

Source files
------------

// File: rtl/grid_vga_display_pkg.sv
// Raster timing constants, grid geometry and colour defaults shared by the
// grid VGA display and its timing generator.
package grid_vga_display_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int GRID_W  = 16;
  localparam int GRID_H  = 16;
  localparam int CNT_W   = 10;

  typedef logic [11:0] rgb_t;

  localparam rgb_t FILL_COLOR  = 12'hF80;
  localparam rgb_t EMPTY_COLOR = 12'h111;
  localparam rgb_t LINE_COLOR  = 12'h444;

  // True when lo <= x < lo+len; the counter is zero-extended so the compare is never negative.
  function automatic logic in_window(input logic [CNT_W-1:0] x, input int lo, input int len);
    int xi;
    xi = int'(x);
    return (xi >= lo) && (xi < lo + len);
  endfunction

endpackage

// File: rtl/grid_vga_display_timing.sv
// Pixel-tick divider plus horizontal/vertical raster counters with raw
// active-low syncs and a visible-area flag, all derived from the current count.
module grid_vga_display_timing
  import grid_vga_display_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = H_VIS,
  parameter int H_FRONT    = H_FP,
  parameter int H_SYNC_LEN = H_SYNC,
  parameter int H_BACK     = H_BP,
  parameter int V_ACTIVE   = V_VIS,
  parameter int V_FRONT    = V_FP,
  parameter int V_SYNC_LEN = V_SYNC,
  parameter int V_BACK     = V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic             tick,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             hs_raw,
  output logic             vs_raw,
  output logic             visible
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC_LEN + H_BACK;
  localparam int V_TOT = V_ACTIVE + V_FRONT + V_SYNC_LEN + V_BACK;

  logic [DIV_W-1:0] div;

  assign tick = (div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset)    div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  // Counters move only on tick, so a reset always restarts the raster at (0,0).
  always_ff @(posedge clk) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      if (h == CNT_W'(H_TOT - 1)) begin
        h <= '0;
        v <= (v == CNT_W'(V_TOT - 1)) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign hs_raw  = !in_window(h, H_ACTIVE + H_FRONT, H_SYNC_LEN);
  assign vs_raw  = !in_window(v, V_ACTIVE + V_FRONT, V_SYNC_LEN);
  assign visible = in_window(h, 0, H_ACTIVE) && in_window(v, 0, V_ACTIVE);

endmodule

// File: rtl/grid_vga_display.sv
// Renders a 16x16 playfield bit-vector as outlined cells on VGA, sampling the
// grid once per frame at the start of vertical blanking to avoid tearing.
module grid_vga_display
  import grid_vga_display_pkg::*;
#(
  parameter int   CLK_DIV    = 4,
  parameter int   CELL_PX    = 16,
  parameter int   X0         = 192,
  parameter int   Y0         = 112,
  parameter rgb_t FILL_RGB   = FILL_COLOR,
  parameter rgb_t EMPTY_RGB  = EMPTY_COLOR,
  parameter rgb_t LINE_RGB   = LINE_COLOR,
  parameter int   H_ACTIVE   = H_VIS,
  parameter int   H_FRONT    = H_FP,
  parameter int   H_SYNC_LEN = H_SYNC,
  parameter int   H_BACK     = H_BP,
  parameter int   V_ACTIVE   = V_VIS,
  parameter int   V_FRONT    = V_FP,
  parameter int   V_SYNC_LEN = V_SYNC,
  parameter int   V_BACK     = V_BP
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [GRID_W*GRID_H-1:0]   grid_in,
  output logic [3:0]                 vga_r,
  output logic [3:0]                 vga_g,
  output logic [3:0]                 vga_b,
  output logic                       vga_hs,
  output logic                       vga_vs,
  output logic                       frame_start
);

  localparam int CELLS   = GRID_W * GRID_H;
  localparam int CELL_SH = $clog2(CELL_PX);
  localparam int PF_W    = GRID_W * CELL_PX;
  localparam int PF_H    = GRID_H * CELL_PX;

  logic             vld_p0;
  logic [CNT_W-1:0] h_p0;
  logic [CNT_W-1:0] v_p0;
  logic             hs_p0;
  logic             vs_p0;
  logic             visible_p0;
  logic             snap_take;
  logic [CELLS-1:0] snapshot;
  rgb_t             rgb_p1;
  logic             hs_p1;
  logic             vs_p1;

  // Cell index and in-cell offset come from shifts and masks of the
  // playfield-relative position; the window test guards the wrapped subtraction.
  function automatic rgb_t cell_colour(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v,
                                       input logic [CELLS-1:0] snap);
    logic [CNT_W-1:0]   dx;
    logic [CNT_W-1:0]   dy;
    logic [3:0]         cx;
    logic [3:0]         cy;
    logic [CELL_SH-1:0] px;
    logic [CELL_SH-1:0] py;
    rgb_t               c;
    dx = h - CNT_W'(X0);
    dy = v - CNT_W'(Y0);
    cx = 4'(dx >> CELL_SH);
    cy = 4'(dy >> CELL_SH);
    px = dx[CELL_SH-1:0];
    py = dy[CELL_SH-1:0];
    c  = '0;
    if (in_window(h, X0, PF_W) && in_window(v, Y0, PF_H)) begin
      if (px == '0 || py == '0) c = LINE_RGB;
      else if (snap[{cx, cy}])  c = FILL_RGB;
      else                      c = EMPTY_RGB;
    end
    return c;
  endfunction

  // Stage p0: raster position and tick
  grid_vga_display_timing #(
    .CLK_DIV    (CLK_DIV),
    .H_ACTIVE   (H_ACTIVE),
    .H_FRONT    (H_FRONT),
    .H_SYNC_LEN (H_SYNC_LEN),
    .H_BACK     (H_BACK),
    .V_ACTIVE   (V_ACTIVE),
    .V_FRONT    (V_FRONT),
    .V_SYNC_LEN (V_SYNC_LEN),
    .V_BACK     (V_BACK)
  ) u_timing (
    .clk     (clk),
    .reset   (reset),
    .tick    (vld_p0),
    .h       (h_p0),
    .v       (v_p0),
    .hs_raw  (hs_p0),
    .vs_raw  (vs_p0),
    .visible (visible_p0)
  );

  assign snap_take = vld_p0 && (h_p0 == '0) && (v_p0 == CNT_W'(V_ACTIVE));

  // Stage p1: registered pins, updated only on tick
  always_ff @(posedge clk) begin
    if (!reset) begin
      snapshot    <= '0;
      rgb_p1      <= '0;
      hs_p1       <= 1'b1;
      vs_p1       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= snap_take;
      if (snap_take) snapshot <= grid_in;
      if (vld_p0) begin
        rgb_p1 <= visible_p0 ? cell_colour(h_p0, v_p0, snapshot) : '0;
        hs_p1  <= hs_p0;
        vs_p1  <= vs_p0;
      end
    end
  end

  assign vga_r  = rgb_p1[11:8];
  assign vga_g  = rgb_p1[7:4];
  assign vga_b  = rgb_p1[3:0];
  assign vga_hs = hs_p1;
  assign vga_vs = vs_p1;

endmodule

// File: tb/tb_grid_vga_display.sv
// Bench for grid_vga_display: a full-size instance for line timing and a
// shrunken-raster instance for frame, snapshot and pixel behaviour.
module tb_grid_vga_display;

  localparam int S_DIV  = 2;
  localparam int S_CELL = 2;
  localparam int S_X0   = 4;
  localparam int S_Y0   = 2;
  localparam int S_HV = 40, S_HF = 2, S_HS = 4, S_HB = 2;
  localparam int S_VV = 36, S_VF = 1, S_VS = 2, S_VB = 2;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int S_FRAME_CLK = S_FRAME * S_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic         reset_a, reset_b;
  logic [255:0] grid_a, grid_b;
  logic [3:0]   r_a, g_a, b_a, r_b, g_b, b_b;
  logic         hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;

  grid_vga_display dut_a (
    .clk(clk), .reset(reset_a), .grid_in(grid_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .frame_start(fs_a)
  );

  grid_vga_display #(
    .CLK_DIV(S_DIV), .CELL_PX(S_CELL), .X0(S_X0), .Y0(S_Y0),
    .H_ACTIVE(S_HV), .H_FRONT(S_HF), .H_SYNC_LEN(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VV), .V_FRONT(S_VF), .V_SYNC_LEN(S_VS), .V_BACK(S_VB)
  ) dut_b (
    .clk(clk), .reset(reset_b), .grid_in(grid_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .frame_start(fs_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference pixel straight from the geometry rules, using division and modulo.
  function automatic logic [11:0] ref_pixel(input int h, input int v, input logic [255:0] snap);
    int cx, cy, px, py;
    if (h >= S_HV || v >= S_VV) return 12'h000;
    if (h < S_X0 || h >= S_X0 + 16 * S_CELL || v < S_Y0 || v >= S_Y0 + 16 * S_CELL) return 12'h000;
    cx = (h - S_X0) / S_CELL;
    px = (h - S_X0) % S_CELL;
    cy = (v - S_Y0) / S_CELL;
    py = (v - S_Y0) % S_CELL;
    if (px == 0 || py == 0) return 12'h444;
    return snap[cx * 16 + cy] ? 12'hF80 : 12'h111;
  endfunction

  // Model of the small instance: tick number since release gives raster position.
  bit           armed_b = 1'b0;
  int           n_b = 0;
  int           m_pos, m_h, m_v;
  int           m_last_h = -1;
  int           m_last_v = -1;
  logic [255:0] m_snap = '0;
  logic [11:0]  e_rgb = '0;
  logic         e_hs = 1'b1, e_vs = 1'b1, e_fs = 1'b0;

  always @(posedge clk) begin
    if (reset_b === 1'b0) begin
      armed_b = 1'b1; n_b = 0; m_snap = '0; e_rgb = '0;
      e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; m_last_h = -1; m_last_v = -1;
    end else if (armed_b) begin
      n_b++;
      e_fs = 1'b0;
      if (n_b % S_DIV == 0) begin
        m_pos = (n_b / S_DIV - 1) % S_FRAME;
        m_h = m_pos % S_HT;
        m_v = m_pos / S_HT;
        e_rgb = ref_pixel(m_h, m_v, m_snap);
        e_hs = !(m_h >= S_HV + S_HF && m_h < S_HV + S_HF + S_HS);
        e_vs = !(m_v >= S_VV + S_VF && m_v < S_VV + S_VF + S_VS);
        if (m_h == 0 && m_v == S_VV) begin
          e_fs = 1'b1;
          m_snap = grid_b;
        end
        m_last_h = m_h;
        m_last_v = m_v;
      end
    end
  end

  always @(negedge clk) begin
    if (armed_b)
      check("model_b", {fs_b, hs_b, vs_b, r_b, g_b, b_b}, {e_fs, e_hs, e_vs, e_rgb});
  end

  task automatic wait_fs_b(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * S_FRAME_CLK && !seen; i++) begin
      @(negedge clk);
      if (fs_b) seen = 1'b1;
    end
    if (!seen) check({"timeout_", name}, 0, 1);
  endtask

  task automatic wait_pos_b(input int h, input int v, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * S_FRAME_CLK && !seen; i++) begin
      @(negedge clk);
      if (m_last_h == h && m_last_v == v) seen = 1'b1;
    end
    if (!seen) check({"timeout_", name}, 0, 1);
  endtask

  // Full-size raster: reset values and horizontal timing over two lines.
  task automatic seq_a();
    int cnt, fall1, rise1, fall2, low_cnt, rgb_bad, vs_bad, fs_cnt;
    logic prev_hs;
    grid_a = '1;
    reset_a = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_hs", hs_a, 1);
    check("rst_vs", vs_a, 1);
    check("rst_rgb", {r_a, g_a, b_a}, 0);
    check("rst_fs", fs_a, 0);
    reset_a = 1'b1;
    cnt = 0; fall1 = -1; rise1 = -1; fall2 = -1;
    low_cnt = 0; rgb_bad = 0; vs_bad = 0; fs_cnt = 0;
    prev_hs = hs_a;
    repeat (6000) begin
      @(negedge clk);
      cnt++;
      if (prev_hs && !hs_a) begin
        if (fall1 < 0) fall1 = cnt;
        else if (fall2 < 0) fall2 = cnt;
      end
      if (!prev_hs && hs_a && rise1 < 0) rise1 = cnt;
      if (!hs_a && cnt <= 3200) low_cnt++;
      if ({r_a, g_a, b_a} != 12'h000) rgb_bad++;
      if (!vs_a) vs_bad++;
      if (fs_a) fs_cnt++;
      prev_hs = hs_a;
    end
    check("hs_fall_clk", fall1, 2628);
    check("hs_rise_clk", rise1, 3012);
    check("hs_fall2_clk", fall2, 2628 + 3200);
    check("hs_low_clks", low_cnt, 384);
    check("top_rows_black", rgb_bad, 0);
    check("vs_high_line0", vs_bad, 0);
    check("no_fs_line0", fs_cnt, 0);
  endtask

  typedef struct {
    logic [255:0] grid;
    int           h;
    int           v;
    logic [11:0]  rgb;
  } pix_vec_t;

  // Small raster: pixel table, tear-free snapshot, frame timing, random, mid-frame reset.
  task automatic seq_b();
    pix_vec_t     vecs[15];
    logic [255:0] g1, g2, g3;
    int           cnt, vs_low, fs_extra;
    bit           seen;
    g1 = '0; g1[0] = 1'b1; g1[17] = 1'b1; g1[255] = 1'b1;
    g2 = '0; g2[16] = 1'b1; g2[1] = 1'b1;
    g3 = '0; g3[5 * 16 + 10] = 1'b1;
    vecs[0]  = '{g1, 5, 2, 12'h444};
    vecs[1]  = '{g1, 3, 3, 12'h000};
    vecs[2]  = '{g1, 4, 3, 12'h444};
    vecs[3]  = '{g1, 5, 3, 12'hF80};
    vecs[4]  = '{g1, 7, 3, 12'h111};
    vecs[5]  = '{g1, 7, 5, 12'hF80};
    vecs[6]  = '{g1, 35, 32, 12'h444};
    vecs[7]  = '{g1, 35, 33, 12'hF80};
    vecs[8]  = '{g1, 36, 33, 12'h000};
    vecs[9]  = '{g2, 5, 3, 12'h111};
    vecs[10] = '{g2, 7, 3, 12'hF80};
    vecs[11] = '{g2, 5, 5, 12'hF80};
    vecs[12] = '{g2, 7, 5, 12'h111};
    vecs[13] = '{g2, 5, 34, 12'h000};
    vecs[14] = '{g2, 44, 10, 12'h000};

    grid_b = '0;
    reset_b = 1'b0;
    repeat (5) @(negedge clk);
    reset_b = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (i == 0 || vecs[i].grid != vecs[i - 1].grid) begin
        grid_b = vecs[i].grid;
        wait_fs_b("vec_fs");
      end
      wait_pos_b(vecs[i].h, vecs[i].v, "vec_pos");
      check($sformatf("pix_%0d_%0d", vecs[i].h, vecs[i].v), {r_b, g_b, b_b}, vecs[i].rgb);
    end

    grid_b = g3;
    wait_fs_b("tear_fs");
    wait_pos_b(0, 15, "tear_mid");
    grid_b = '0;
    wait_pos_b(15, 23, "tear_old");
    check("tear_old_frame", {r_b, g_b, b_b}, 12'hF80);
    wait_fs_b("tear_fs2");
    wait_pos_b(15, 23, "tear_new");
    check("tear_new_frame", {r_b, g_b, b_b}, 12'h111);

    wait_fs_b("period_fs");
    cnt = 0; vs_low = 0; seen = 1'b0; fs_extra = 0;
    while (!seen && cnt < 2 * S_FRAME_CLK) begin
      @(negedge clk);
      cnt++;
      if (!vs_b) vs_low++;
      if (fs_b) seen = 1'b1;
    end
    check("frame_period_clk", cnt, S_FRAME_CLK);
    check("vs_low_clk", vs_low, 2 * S_HT * S_DIV);

    repeat (3 * S_FRAME_CLK) begin
      @(negedge clk);
      if (fs_b) fs_extra++;
      if ($urandom_range(0, 39) == 0)
        for (int j = 0; j < 8; j++) grid_b[j * 32 +: 32] = $urandom;
    end
    check("fs_per_3_frames", fs_extra, 3);

    wait_pos_b(30, 20, "rst_pos");
    reset_b = 1'b0;
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 3 * S_FRAME_CLK) begin
      @(negedge clk);
      cnt++;
      if (fs_b) seen = 1'b1;
    end
    check("restart_fs_clk", cnt, S_DIV * (S_VV * S_HT + 1));
  endtask

  initial begin
    reset_a = 1'b0; reset_b = 1'b0;
    grid_a = '0; grid_b = '0;
    fork
      seq_a();
      seq_b();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
